data_mem_ctrl: RTL

Parametrised data-memory controller for the RV32I core's memory stage. It replaces the fixed 1 K-word data cache with a configurable-depth, byte-lane-masked block RAM. It performs sign/zero-extended byte, half and word loads and lane-correct byte/half/word stores, and holds a memory-mapped LED register. It stalls the core through `clk_stall` for the duration of each access.

---
 rtl/data_mem_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: byte-lane-masked block RAM plus a memory-mapped LED register.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned half/word accesses with a one-cycle fault pulse.
module data_mem_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] LED_ADDR    = 32'h0000_2000,
    parameter int          LED_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          addr,
    input  logic [31:0]          write_data,
    input  logic                 memwrite,
    input  logic                 memread,
    input  logic [3:0]           sign_mask,
    output logic [31:0]          read_data,
    output logic                 clk_stall,
    output logic [LED_WIDTH-1:0] led,
    output logic                 fault
);

    localparam int          IDX_W        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] WINDOW_BYTES = 33'(DEPTH_WORDS) << 2;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] READ  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       mask_q, mask_d;
    logic [31:0]      read_data_q, read_data_d;
    logic             stall_q, stall_d;
    logic [31:0]      led_q, led_d;

    logic [31:0]      offset;
    logic             in_range;
    logic             led_hit;
    logic             misaligned;
    logic [1:0]       lane;
    logic [3:0]       lane_be;
    logic [31:0]      wdata_rep;
    logic [IDX_W-1:0] ram_idx;
    logic [3:0]       ram_be;
    logic [31:0]      ram_rdata;
    logic [31:0]      src_word;
    logic [31:0]      shifted;
    logic [31:0]      load_val;
    logic [31:0]      mem [DEPTH_WORDS];

    assign offset   = addr_q - BASE_ADDR;
    assign in_range = (addr_q >= BASE_ADDR) && ({1'b0, offset} < WINDOW_BYTES);
    assign led_hit  = (addr_q[31:2] == LED_ADDR[31:2]);
    assign ram_idx  = offset[IDX_W+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    logic fault_q, fault_d;

    assign misaligned = (mask_q[2] && (addr_q[1:0] != 2'b00)) ||
                        (!mask_q[2] && mask_q[1] && addr_q[0]);

    always_comb begin
        fault_d = ((state_q == READ) || (state_q == WRITE)) && misaligned;
    end

    always_ff @(posedge clk) begin
        if (reset) fault_q <= 1'b0;
        else       fault_q <= fault_d;
    end

    assign fault = fault_q;
`else
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
`endif

    // Lane selection ignores the low address bits a half/word access cannot use.
    always_comb begin
        lane      = addr_q[1:0];
        lane_be   = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
        if (mask_q[2]) begin
            lane      = 2'b00;
            lane_be   = 4'b1111;
            wdata_rep = wdata_q;
        end else if (mask_q[1]) begin
            lane      = {addr_q[1], 1'b0};
            lane_be   = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
        end
    end

    always_comb begin
        src_word = 32'h0;
        if (!misaligned) begin
            if (led_hit)       src_word = led_q;
            else if (in_range) src_word = ram_rdata;
        end
        shifted = src_word >> {lane, 3'b000};
        if (mask_q[2])      load_val = shifted;
        else if (mask_q[1]) load_val = {{16{mask_q[3] & shifted[15]}}, shifted[15:0]};
        else                load_val = {{24{mask_q[3] & shifted[7]}}, shifted[7:0]};
    end

    // Gating with reset keeps a store caught in WRITE at the reset edge from committing.
    assign ram_be = (state_q == WRITE && !reset && in_range && !led_hit && !misaligned)
                    ? lane_be : 4'b0000;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_be[i]) mem[ram_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
        if (state_q == LOAD) ram_rdata <= mem[ram_idx];
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        read_data_d = read_data_q;
        stall_d     = stall_q;
        led_d       = led_q;
        case (state_q)
            IDLE: begin
                addr_d  = addr;
                wdata_d = write_data;
                mask_d  = sign_mask;
                if (memwrite) begin
                    state_d = WRITE;
                    stall_d = 1'b1;
                end else if (memread) begin
                    state_d = LOAD;
                    stall_d = 1'b1;
                end
            end
            LOAD: state_d = READ;
            READ: begin
                read_data_d = load_val;
                stall_d     = 1'b0;
                state_d     = DONE;
            end
            WRITE: begin
                if (led_hit && !misaligned) begin
                    for (int i = 0; i < 4; i++) begin
                        if (lane_be[i]) led_d[8*i +: 8] = wdata_rep[8*i +: 8];
                    end
                end
                stall_d = 1'b0;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            mask_q      <= 4'h0;
            read_data_q <= 32'h0;
            stall_q     <= 1'b0;
            led_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            read_data_q <= read_data_d;
            stall_q     <= stall_d;
            led_q       <= led_d;
        end
    end

    assign read_data = read_data_q;
    assign clk_stall = stall_q;
    assign led       = led_q[LED_WIDTH-1:0];

endmodule
